// File: rtl/pa_wb_pkg.sv
// Shared types and constants for the writeback result FIFO.
package pa_wb_pkg;

  localparam int WB_ADDR_W = 5;
  localparam int WB_DATA_W = 16;
  localparam int STAT_W    = 2;
  localparam int STAT_OVF  = 1;
  localparam int STAT_UNF  = 0;

  typedef struct packed {
    logic [WB_ADDR_W-1:0] addr;
    logic [WB_DATA_W-1:0] value;
    logic [STAT_W-1:0]    status;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo_mem.sv
// Entry storage for the writeback FIFO: two write ports, two asynchronous read
// ports, no reset on the data array.
module wb_fifo_mem
  import pa_wb_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int W     = 23
) (
  input  logic                     clock_i,
  input  logic                     we0_i,
  input  logic [$clog2(DEPTH)-1:0] wa0_i,
  input  logic [W-1:0]             wd0_i,
  input  logic                     we1_i,
  input  logic [$clog2(DEPTH)-1:0] wa1_i,
  input  logic [W-1:0]             wd1_i,
  input  logic [$clog2(DEPTH)-1:0] ra0_i,
  input  logic [$clog2(DEPTH)-1:0] ra1_i,
  output logic [W-1:0]             rd0_o,
  output logic [W-1:0]             rd1_o
);

  logic [W-1:0] mem_q [DEPTH];

  // The two write addresses are always distinct when both ports fire.
  always_ff @(posedge clock_i) begin
    if (we0_i) mem_q[wa0_i] <= wd0_i;
    if (we1_i) mem_q[wa1_i] <= wd1_i;
  end

  assign rd0_o = mem_q[ra0_i];
  assign rd1_o = mem_q[ra1_i];

endmodule

// File: rtl/wb_result_fifo.sv
// Dual-in/dual-out writeback buffer between exec pipes A/B and the register file.
// Optional macro WBFIFO_FORWARD_EN: forward results straight to the outputs when empty.
module wb_result_fifo
  import pa_wb_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = WB_ADDR_W,
  parameter int DATA_W = WB_DATA_W
) (
  input  logic                         clock_i,
  input  logic                         reset_i,
  input  logic                         flush_i,
  input  logic                         resValidA_i,
  input  logic [ADDR_W-1:0]            resAddrA_i,
  input  logic [DATA_W-1:0]            resValA_i,
  input  logic [1:0]                   resStatusA_i,
  input  logic                         resValidB_i,
  input  logic [ADDR_W-1:0]            resAddrB_i,
  input  logic [DATA_W-1:0]            resValB_i,
  input  logic [1:0]                   resStatusB_i,
  output logic                         ready_o,
  output logic                         overflow_o,
  output logic                         wbA_o,
  output logic [ADDR_W-1:0]            wbAddrA_o,
  output logic [DATA_W-1:0]            wbValA_o,
  output logic [1:0]                   operationStatusA_o,
  output logic                         wbB_o,
  output logic [ADDR_W-1:0]            wbAddrB_o,
  output logic [DATA_W-1:0]            wbValB_o,
  output logic [1:0]                   operationStatusB_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] value;
    logic [1:0]        status;
  } entry_t;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d, ready_q, ready_d;
  logic             wb_a_q, wb_a_d, wb_b_q, wb_b_d;
  entry_t           out_a_q, out_a_d, out_b_q, out_b_d;

  entry_t           entry_a, entry_b, head, second, wd0;
  logic [PTR_W-1:0] wa1;
  logic             fwd, fwd_b, push_a, push_b, acc_a, acc_b, pop_a, pop_b, we0, we1;
  logic [1:0]       n_push, n_pop;

  assign entry_a = {resAddrA_i, resValA_i, resStatusA_i};
  assign entry_b = {resAddrB_i, resValB_i, resStatusB_i};

  wb_fifo_mem #(.DEPTH(DEPTH), .W($bits(entry_t))) u_mem (
    .clock_i (clock_i),
    .we0_i   (we0),
    .wa0_i   (wr_ptr_q),
    .wd0_i   (wd0),
    .we1_i   (we1),
    .wa1_i   (wa1),
    .wd1_i   (entry_b),
    .ra0_i   (rd_ptr_q),
    .ra1_i   (rd_ptr_q + PTR_W'(1)),
    .rd0_o   (head),
    .rd1_o   (second)
  );

  always_comb begin
`ifdef WBFIFO_FORWARD_EN
    fwd = (count_q == '0) && !flush_i;
`else
    fwd = 1'b0;
`endif
    // A same-address B cannot share a cycle with A, so it is stored instead.
    fwd_b  = fwd && resValidB_i && !(resValidA_i && (resAddrA_i == resAddrB_i));
    push_a = resValidA_i && !fwd && !flush_i;
    push_b = resValidB_i && !fwd_b && !flush_i;
    acc_a  = push_a && (count_q < DEPTH_C);
    acc_b  = push_b && ((count_q + CNT_W'(acc_a)) < DEPTH_C);
    pop_a  = (count_q != '0);
    pop_b  = (count_q >= CNT_W'(2)) && (head.addr != second.addr);
    n_push = {1'b0, acc_a} + {1'b0, acc_b};
    n_pop  = {1'b0, pop_a} + {1'b0, pop_b};

    we0 = acc_a || acc_b;
    wd0 = acc_a ? entry_a : entry_b;
    we1 = acc_a && acc_b;
    wa1 = wr_ptr_q + PTR_W'(1);

    wr_ptr_d = wr_ptr_q + PTR_W'(n_push);
    rd_ptr_d = rd_ptr_q + PTR_W'(n_pop);
    count_d  = count_q + CNT_W'(n_push) - CNT_W'(n_pop);
    ovf_d    = ovf_q || (push_a && !acc_a) || (push_b && !acc_b);
    wb_a_d   = pop_a;
    out_a_d  = pop_a ? head : '0;
    wb_b_d   = pop_b;
    out_b_d  = pop_b ? second : '0;

    if (fwd && resValidA_i) begin
      wb_a_d  = 1'b1;
      out_a_d = entry_a;
    end
    if (fwd_b) begin
      wb_b_d  = 1'b1;
      out_b_d = entry_b;
    end

    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      wb_a_d   = 1'b0;
      out_a_d  = '0;
      wb_b_d   = 1'b0;
      out_b_d  = '0;
    end

    ready_d = (DEPTH_C - count_d) >= CNT_W'(2);
  end

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      ready_q  <= 1'b1;
      wb_a_q   <= 1'b0;
      out_a_q  <= '0;
      wb_b_q   <= 1'b0;
      out_b_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      ready_q  <= ready_d;
      wb_a_q   <= wb_a_d;
      out_a_q  <= out_a_d;
      wb_b_q   <= wb_b_d;
      out_b_q  <= out_b_d;
    end
  end

  assign ready_o            = ready_q;
  assign overflow_o         = ovf_q;
  assign count_o            = count_q;
  assign wbA_o              = wb_a_q;
  assign wbAddrA_o          = out_a_q.addr;
  assign wbValA_o           = out_a_q.value;
  assign operationStatusA_o = out_a_q.status;
  assign wbB_o              = wb_b_q;
  assign wbAddrB_o          = out_b_q.addr;
  assign wbValB_o           = out_b_q.value;
  assign operationStatusB_o = out_b_q.status;

endmodule

// File: tb/tb_wb_result_fifo.sv
// Self-checking bench for wb_result_fifo (default build): queue-level reference
// model checked every cycle, plus directed scenarios with literal expectations.
module tb_wb_result_fifo;

  localparam int DEPTH = 8;

  logic        clock_i = 1'b0;
  logic        reset_i;
  logic        flush_i;
  logic        resValidA_i, resValidB_i;
  logic [4:0]  resAddrA_i, resAddrB_i;
  logic [15:0] resValA_i, resValB_i;
  logic [1:0]  resStatusA_i, resStatusB_i;
  logic        ready_o, overflow_o, wbA_o, wbB_o;
  logic [4:0]  wbAddrA_o, wbAddrB_o;
  logic [15:0] wbValA_o, wbValB_o;
  logic [1:0]  operationStatusA_o, operationStatusB_o;
  logic [3:0]  count_o;

  int compareCount  = 0;
  int mismatchCount = 0;

  wb_result_fifo #(.DEPTH(DEPTH), .ADDR_W(5), .DATA_W(16)) dut (
    .clock_i            (clock_i),
    .reset_i            (reset_i),
    .flush_i            (flush_i),
    .resValidA_i        (resValidA_i),
    .resAddrA_i         (resAddrA_i),
    .resValA_i          (resValA_i),
    .resStatusA_i       (resStatusA_i),
    .resValidB_i        (resValidB_i),
    .resAddrB_i         (resAddrB_i),
    .resValB_i          (resValB_i),
    .resStatusB_i       (resStatusB_i),
    .ready_o            (ready_o),
    .overflow_o         (overflow_o),
    .wbA_o              (wbA_o),
    .wbAddrA_o          (wbAddrA_o),
    .wbValA_o           (wbValA_o),
    .operationStatusA_o (operationStatusA_o),
    .wbB_o              (wbB_o),
    .wbAddrB_o          (wbAddrB_o),
    .wbValB_o           (wbValB_o),
    .operationStatusB_o (operationStatusB_o),
    .count_o            (count_o)
  );

  always #5 clock_i = ~clock_i;

  typedef struct {
    logic [4:0]  addr;
    logic [15:0] value;
    logic [1:0]  status;
  } mentry_t;

  mentry_t     modelQ[$];
  mentry_t     arrivals[$];
  mentry_t     tmp;
  int          held, taken, pops;
  logic        expWbA = 0, expWbB = 0, expOvf = 0, expReady = 1;
  logic [4:0]  expAddrA = 0, expAddrB = 0;
  logic [15:0] expValA = 0, expValB = 0;
  logic [1:0]  expStatA = 0, expStatB = 0;
  int          expCount = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compareCount++;
    if (act !== exp) begin
      mismatchCount++;
      $display("[TB] FAIL %s: actual 0x%0h, required 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic va, input logic [4:0] aa, input logic [15:0] da,
                               input logic [1:0] sa, input logic vb, input logic [4:0] ab,
                               input logic [15:0] db, input logic [1:0] sb, input logic fl);
    resValidA_i = va; resAddrA_i = aa; resValA_i = da; resStatusA_i = sa;
    resValidB_i = vb; resAddrB_i = ab; resValB_i = db; resStatusB_i = sb;
    flush_i     = fl;
  endtask

  task automatic clearExpWb();
    expWbA = 0; expAddrA = 0; expValA = 0; expStatA = 0;
    expWbB = 0; expAddrB = 0; expValB = 0; expStatB = 0;
  endtask

  // Reference model: results live in an ordered queue; each edge the outputs take the
  // oldest (and a differently-addressed second-oldest), arrivals join by available room.
  always @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      modelQ.delete();
      clearExpWb();
      expOvf   = 0;
      expReady = 1;
    end else if (flush_i) begin
      modelQ.delete();
      clearExpWb();
      expReady = 1;
    end else begin
      held = modelQ.size();
      clearExpWb();
      if (held >= 1) begin
        expWbA = 1; expAddrA = modelQ[0].addr; expValA = modelQ[0].value; expStatA = modelQ[0].status;
      end
      if (held >= 2 && modelQ[1].addr != modelQ[0].addr) begin
        expWbB = 1; expAddrB = modelQ[1].addr; expValB = modelQ[1].value; expStatB = modelQ[1].status;
      end
      taken = 0;
      arrivals.delete();
      if (resValidA_i) begin
        if (held + taken < DEPTH) begin
          tmp.addr = resAddrA_i; tmp.value = resValA_i; tmp.status = resStatusA_i;
          arrivals.push_back(tmp);
          taken++;
        end else expOvf = 1;
      end
      if (resValidB_i) begin
        if (held + taken < DEPTH) begin
          tmp.addr = resAddrB_i; tmp.value = resValB_i; tmp.status = resStatusB_i;
          arrivals.push_back(tmp);
          taken++;
        end else expOvf = 1;
      end
      pops = int'(expWbA) + int'(expWbB);
      for (int k = 0; k < pops; k++) void'(modelQ.pop_front());
      foreach (arrivals[k]) modelQ.push_back(arrivals[k]);
      expReady = (DEPTH - modelQ.size()) >= 2;
    end
    expCount = modelQ.size();
  end

  // Every falling edge the DUT outputs must equal the model.
  always @(negedge clock_i) begin
    checkOutput("m_wbA",    wbA_o,              expWbA);
    checkOutput("m_addrA",  wbAddrA_o,          expAddrA);
    checkOutput("m_valA",   wbValA_o,           expValA);
    checkOutput("m_statA",  operationStatusA_o, expStatA);
    checkOutput("m_wbB",    wbB_o,              expWbB);
    checkOutput("m_addrB",  wbAddrB_o,          expAddrB);
    checkOutput("m_valB",   wbValB_o,           expValB);
    checkOutput("m_statB",  operationStatusB_o, expStatB);
    checkOutput("m_count",  count_o,            expCount);
    checkOutput("m_ready",  ready_o,            expReady);
    checkOutput("m_ovf",    overflow_o,         expOvf);
  end

  // Directed scenarios with hand-computed literal expectations.
  initial begin
    reset_i = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clock_i);
    checkOutput("rst_wbA", wbA_o, 0);
    checkOutput("rst_wbB", wbB_o, 0);
    checkOutput("rst_count", count_o, 0);
    checkOutput("rst_ready", ready_o, 1);
    checkOutput("rst_ovf", overflow_o, 0);
    reset_i = 1'b1;

    applyStimulus(1, 3, 16'h1234, 2'b10, 0, 0, 0, 0, 0);
    @(negedge clock_i);
    checkOutput("t1_count_held", count_o, 1);
    checkOutput("t1_wbA_early", wbA_o, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clock_i);
    checkOutput("t1_wbA", wbA_o, 1);
    checkOutput("t1_addrA", wbAddrA_o, 3);
    checkOutput("t1_valA", wbValA_o, 32'h1234);
    checkOutput("t1_statA", operationStatusA_o, 2);
    checkOutput("t1_wbB", wbB_o, 0);
    checkOutput("t1_count", count_o, 0);

    applyStimulus(1, 5, 16'h0001, 0, 1, 6, 16'h0002, 0, 0);
    @(negedge clock_i);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clock_i);
    checkOutput("t2_wbA", wbA_o, 1);
    checkOutput("t2_addrA", wbAddrA_o, 5);
    checkOutput("t2_wbB", wbB_o, 1);
    checkOutput("t2_addrB", wbAddrB_o, 6);
    checkOutput("t2_valB", wbValB_o, 2);

    applyStimulus(1, 7, 16'h00AA, 0, 1, 7, 16'h00BB, 0, 0);
    @(negedge clock_i);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clock_i);
    checkOutput("t3_e1_addrA", wbAddrA_o, 7);
    checkOutput("t3_e1_valA", wbValA_o, 32'hAA);
    checkOutput("t3_e1_wbB", wbB_o, 0);
    @(negedge clock_i);
    checkOutput("t3_e2_wbA", wbA_o, 1);
    checkOutput("t3_e2_valA", wbValA_o, 32'hBB);
    checkOutput("t3_e2_wbB", wbB_o, 0);

    // Same-address pairs drain one per cycle, so occupancy climbs by one per cycle.
    for (int i = 0; i < 7; i++) begin
      if (i < 6) applyStimulus(1, 9, 16'(2*i), 0, 1, 9, 16'(2*i+1), 0, 0);
      else       applyStimulus(1, 9, 16'h0C00, 1, 1, 1, 16'hFFFF, 2, 0);
      @(negedge clock_i);
    end
    checkOutput("t4_count", count_o, 7);
    checkOutput("t4_ready", ready_o, 0);
    checkOutput("t4_ovf", overflow_o, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (9) @(negedge clock_i);
    checkOutput("t4_drained", count_o, 0);
    checkOutput("t4_ovf_sticky", overflow_o, 1);
    checkOutput("t4_ready_back", ready_o, 1);

    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 12, 16'(16'h0100 + 2*i), 0, 1, 12, 16'(16'h0101 + 2*i), 0, 0);
      @(negedge clock_i);
    end
    checkOutput("t5_count_pre", count_o, 4);
    applyStimulus(1, 13, 16'hDEAD, 0, 1, 14, 16'hBEEF, 0, 1);
    @(negedge clock_i);
    checkOutput("t5_count", count_o, 0);
    checkOutput("t5_wbA", wbA_o, 0);
    checkOutput("t5_wbB", wbB_o, 0);
    checkOutput("t5_ready", ready_o, 1);
    checkOutput("t5_ovf_kept", overflow_o, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clock_i);
    checkOutput("t5_no_ghost", wbA_o, 0);

    applyStimulus(1, 20, 16'h2020, 0, 1, 21, 16'h2121, 0, 0);
    @(negedge clock_i);
    applyStimulus(1, 22, 16'h2222, 0, 1, 23, 16'h2323, 0, 0);
    @(negedge clock_i);
    checkOutput("t6_addrA_pre", wbAddrA_o, 20);
    checkOutput("t6_count_pre", count_o, 2);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #2 reset_i = 1'b0;
    #1;
    checkOutput("t6_wbA", wbA_o, 0);
    checkOutput("t6_wbB", wbB_o, 0);
    checkOutput("t6_count", count_o, 0);
    checkOutput("t6_ovf", overflow_o, 0);
    checkOutput("t6_ready", ready_o, 1);
    repeat (2) @(negedge clock_i);
    reset_i = 1'b1;
    repeat (3) @(negedge clock_i);
    checkOutput("t6_after_wbA", wbA_o, 0);
    checkOutput("t6_after_count", count_o, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
